// File: rtl/fifo_top.sv
// Single-clock FIFO with first-word-fall-through read data.
// Wrap-bit pointers give unambiguous full/empty without an occupancy counter.
module fifo_top #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int P_SIZE     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  W_INC,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  R_INC,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  FULL,
  output logic                  EMPTY
);

  localparam int A_W = P_SIZE - 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [P_SIZE-1:0]     wptr_q, wptr_d;
  logic [P_SIZE-1:0]     rptr_q, rptr_d;
  logic                  wr_en, rd_en;

  assign wr_en = W_INC & ~FULL;
  assign rd_en = R_INC & ~EMPTY;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_en) wptr_d = wptr_q + P_SIZE'(1);
    if (rd_en) rptr_d = rptr_q + P_SIZE'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is deliberately left unreset; the write is still blocked on a reset edge.
  always_ff @(posedge CLK) begin
    if (RST && wr_en) mem_q[wptr_q[A_W-1:0]] <= WR_DATA;
  end

  assign RD_DATA = mem_q[rptr_q[A_W-1:0]];
  assign EMPTY   = (wptr_q == rptr_q);
  assign FULL    = (wptr_q[P_SIZE-1] != rptr_q[P_SIZE-1]) &&
                   (wptr_q[A_W-1:0] == rptr_q[A_W-1:0]);

endmodule

// File: tb/tb_fifo_top.sv
// Scenario bench for fifo_top: a queue scoreboard holds the words expected
// to come out, and each scenario task compares DUT outputs against it.
module tb_fifo_top;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          CLK;
  logic          RST;
  logic          W_INC;
  logic [DW-1:0] WR_DATA;
  logic          R_INC;
  logic [DW-1:0] RD_DATA;
  logic          FULL;
  logic          EMPTY;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] sb[$];

  fifo_top #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .P_SIZE(4)) dut (
    .CLK(CLK), .RST(RST), .W_INC(W_INC), .WR_DATA(WR_DATA),
    .R_INC(R_INC), .RD_DATA(RD_DATA), .FULL(FULL), .EMPTY(EMPTY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required<200000", $time);
    $fatal(1);
  end

  // One clock edge of stimulus; the scoreboard decides from its own occupancy
  // whether the read/write qualifies, and reports the head word seen pre-edge.
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r,
                       output logic popped, output logic [DW-1:0] exp_d,
                       output logic [DW-1:0] got_d);
    logic wr_ok;
    W_INC = w; WR_DATA = d; R_INC = r;
    #1;
    got_d  = RD_DATA;
    popped = r && (sb.size() > 0);
    exp_d  = popped ? sb[0] : '0;
    wr_ok  = w && (sb.size() < DEPTH);
    @(posedge CLK); #1;
    if (popped) void'(sb.pop_front());
    if (wr_ok) sb.push_back(d);
    W_INC = 1'b0; R_INC = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0; W_INC = 1'b0; R_INC = 1'b0; WR_DATA = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    sb.delete();
    checks++;
    if (EMPTY !== 1'b1) begin errors++; $display("FAIL reset_empty: got=%b exp=1", EMPTY); end
    checks++;
    if (FULL !== 1'b0) begin errors++; $display("FAIL reset_full: got=%b exp=0", FULL); end
  endtask

  task automatic test_fill();
    logic p; logic [DW-1:0] e, g;
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, DW'(8'h10 + i), 1'b0, p, e, g);
      if (i == 0) begin
        checks++;
        if (EMPTY !== 1'b0) begin errors++; $display("FAIL fill_empty_after_first: got=%b exp=0", EMPTY); end
      end
      checks++;
      if (FULL !== (i == DEPTH-1)) begin
        errors++; $display("FAIL fill_full[%0d]: got=%b exp=%b", i, FULL, (i == DEPTH-1));
      end
    end
    cycle(1'b1, 8'hEE, 1'b0, p, e, g);
    checks++;
    if (FULL !== 1'b1 || EMPTY !== 1'b0) begin
      errors++; $display("FAIL ninth_write_flags: full=%b empty=%b exp full=1 empty=0", FULL, EMPTY);
    end
  endtask

  task automatic test_drain();
    logic p; logic [DW-1:0] e, g;
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, '0, 1'b1, p, e, g);
      checks++;
      if (!p || g !== e) begin errors++; $display("FAIL drain_data[%0d]: got=%h exp=%h", i, g, e); end
    end
    checks++;
    if (EMPTY !== 1'b1) begin errors++; $display("FAIL drain_empty: got=%b exp=1", EMPTY); end
    cycle(1'b0, '0, 1'b1, p, e, g);
    checks++;
    if (EMPTY !== 1'b1 || FULL !== 1'b0) begin
      errors++; $display("FAIL pop_when_empty: empty=%b full=%b exp empty=1 full=0", EMPTY, FULL);
    end
  endtask

  task automatic test_concurrent();
    logic p; logic [DW-1:0] e, g;
    for (int i = 0; i < 4; i++) cycle(1'b1, DW'(8'h40 + i), 1'b0, p, e, g);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, DW'(8'h80 + i * 3), 1'b1, p, e, g);
      checks++;
      if (!p || g !== e) begin errors++; $display("FAIL concurrent_data[%0d]: got=%h exp=%h", i, g, e); end
      checks++;
      if (FULL !== 1'b0 || EMPTY !== 1'b0) begin
        errors++; $display("FAIL concurrent_flags[%0d]: full=%b empty=%b exp 0 0", i, FULL, EMPTY);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b1, p, e, g);
      checks++;
      if (!p || g !== e) begin errors++; $display("FAIL concurrent_tail[%0d]: got=%h exp=%h", i, g, e); end
    end
    checks++;
    if (EMPTY !== 1'b1) begin errors++; $display("FAIL concurrent_end_empty: got=%b exp=1", EMPTY); end
  endtask

  task automatic test_boundary_full();
    logic p; logic [DW-1:0] e, g;
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'($urandom_range(0, 255)), 1'b0, p, e, g);
    cycle(1'b1, 8'h5A, 1'b1, p, e, g);
    checks++;
    if (!p || g !== e) begin errors++; $display("FAIL full_both_data: got=%h exp=%h", g, e); end
    checks++;
    if (FULL !== 1'b0) begin errors++; $display("FAIL full_both_flag: got=%b exp=0", FULL); end
    for (int i = 0; i < DEPTH-1; i++) begin
      cycle(1'b0, '0, 1'b1, p, e, g);
      checks++;
      if (!p || g !== e) begin errors++; $display("FAIL full_both_drain[%0d]: got=%h exp=%h", i, g, e); end
    end
    checks++;
    if (EMPTY !== 1'b1) begin errors++; $display("FAIL full_both_end_empty: got=%b exp=1", EMPTY); end
  endtask

  task automatic test_boundary_empty();
    logic p; logic [DW-1:0] e, g;
    cycle(1'b1, 8'hC3, 1'b1, p, e, g);
    checks++;
    if (EMPTY !== 1'b0) begin errors++; $display("FAIL empty_both_flag: got=%b exp=0", EMPTY); end
    checks++;
    if (RD_DATA !== 8'hC3) begin errors++; $display("FAIL empty_both_fwft: got=%h exp=c3", RD_DATA); end
    cycle(1'b0, '0, 1'b1, p, e, g);
    checks++;
    if (!p || g !== 8'hC3 || EMPTY !== 1'b1) begin
      errors++; $display("FAIL empty_both_pop: got=%h empty=%b exp c3 empty=1", g, EMPTY);
    end
  endtask

  task automatic test_wrap();
    logic p; logic [DW-1:0] e, g, base;
    for (int r = 0; r < 3; r++) begin
      base = DW'($urandom_range(0, 255));
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, base + DW'(i * 37), 1'b0, p, e, g);
      checks++;
      if (FULL !== 1'b1) begin errors++; $display("FAIL wrap_full[%0d]: got=%b exp=1", r, FULL); end
      for (int i = 0; i < DEPTH; i++) begin
        cycle(1'b0, '0, 1'b1, p, e, g);
        checks++;
        if (!p || g !== e) begin errors++; $display("FAIL wrap_data[%0d][%0d]: got=%h exp=%h", r, i, g, e); end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic p; logic [DW-1:0] e, g;
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'(8'h20 + i), 1'b0, p, e, g);
    RST = 1'b0; W_INC = 1'b1; WR_DATA = 8'h33; R_INC = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b1; W_INC = 1'b0; R_INC = 1'b0;
    sb.delete();
    checks++;
    if (EMPTY !== 1'b1 || FULL !== 1'b0) begin
      errors++; $display("FAIL mid_reset_flags: empty=%b full=%b exp empty=1 full=0", EMPTY, FULL);
    end
    cycle(1'b1, 8'hA5, 1'b0, p, e, g);
    checks++;
    if (RD_DATA !== 8'hA5) begin errors++; $display("FAIL mid_reset_readback: got=%h exp=a5", RD_DATA); end
    cycle(1'b0, '0, 1'b1, p, e, g);
    checks++;
    if (!p || g !== e || EMPTY !== 1'b1) begin
      errors++; $display("FAIL mid_reset_pop: got=%h exp=%h empty=%b", g, e, EMPTY);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_concurrent();
    test_boundary_full();
    test_boundary_empty();
    test_wrap();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_top.md
FIFO_TOP -- requirements
Module: fifo_top

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the word width of WR_DATA, RD_DATA and each storage entry.
REQ-002 Parameter FIFO_DEPTH, default 8, SHALL set the number of storage entries; it is a power of two and at least 2.
REQ-003 Parameter P_SIZE, default log2(FIFO_DEPTH)+1 (4), SHALL set the pointer width: address bits plus one wrap bit.
REQ-004 The design SHALL use one clock, and its reset SHALL be synchronous and active-low.
REQ-005 Port CLK, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 Port RST, input, 1 bit: synchronous active-low reset.
REQ-007 Port W_INC, input, 1 bit: write request.
REQ-008 Port WR_DATA, input, DATA_WIDTH bits: write data.
REQ-009 Port R_INC, input, 1 bit: read (pop) request.
REQ-010 Port RD_DATA, output, DATA_WIDTH bits: head-of-queue data.
REQ-011 Port FULL, output, 1 bit: the FIFO holds FIFO_DEPTH words.
REQ-012 Port EMPTY, output, 1 bit: the FIFO holds 0 words.

Function
REQ-013 Storage SHALL be a FIFO_DEPTH x DATA_WIDTH array with P_SIZE-bit write and read pointers; the low P_SIZE-1 bits address the array.
REQ-014 Write qualification:
- A write SHALL occur when W_INC=1 and FULL=0 at a rising edge.
- The write stores WR_DATA at the write address and increments the write pointer modulo 2^P_SIZE.
REQ-015 Write while full: W_INC=1 with FULL=1 SHALL be ignored, with no storage change and no pointer change.
REQ-016 Read qualification:
- A read SHALL occur when R_INC=1 and EMPTY=0 at a rising edge.
- The read increments the read pointer modulo 2^P_SIZE.
REQ-017 Read while empty: R_INC=1 with EMPTY=1 SHALL be ignored.
REQ-018 RD_DATA SHALL be driven combinationally from the entry at the read address (first-word-fall-through).
- The oldest unread word is therefore visible before and during the cycle that pops it, with zero-cycle read latency.
REQ-019 RD_DATA SHALL be don't-care while EMPTY=1.
REQ-020 EMPTY SHALL be 1 exactly when the write and read pointers are equal in all P_SIZE bits.
REQ-021 FULL SHALL be 1 exactly when the pointer MSBs differ and the remaining bits are equal.
REQ-022 FULL and EMPTY SHALL be derived combinationally from the registered pointers.
- They reflect the result of an edge immediately after that edge.
- They SHALL never both be 1.
REQ-023 Simultaneous qualified read and write in one cycle SHALL both take effect, leaving occupancy unchanged.
REQ-024 When FULL=1 and both requests are active, only the read SHALL take effect, and FULL deasserts after the edge.
REQ-025 When EMPTY=1 and both requests are active, only the write SHALL take effect, and EMPTY deasserts after the edge.
REQ-026 Pointer wrap-around SHALL be seamless: data order is preserved across any number of wraps.
REQ-027 Words SHALL be read out in exactly the order they were written, with no loss or duplication.

Reset
REQ-028 When RST=0 at a rising edge, both pointers SHALL become 0, giving EMPTY=1 and FULL=0 after that edge.
REQ-029 Storage contents SHALL NOT be reset.
REQ-030 Reset applied mid-operation SHALL discard all stored words, and W_INC and R_INC SHALL be ignored during that edge.

Verification
REQ-031 Reset then fill: hold RST=0 for 2 edges, then write 8 words in consecutive cycles.
- Required: FULL=1 after the 8th edge, and EMPTY=0 after the 1st edge.
- A 9th write is ignored.
REQ-032 Drain after fill: R_INC=1 each cycle.
- Required: RD_DATA equals the written words in order before each pop.
- EMPTY=1 after the 8th pop, and further pops are ignored.
REQ-033 Concurrent traffic at occupancy 4: W_INC=R_INC=1 for 10 cycles.
- Required: occupancy stays 4 and FULL=EMPTY=0 throughout.
- The read sequence matches the write sequence.
REQ-034 Boundary cases:
- Both requests at FULL: only the read happens, FULL goes 0.
- Both requests at EMPTY: only the write happens, EMPTY goes 0, and RD_DATA shows that word next cycle.
REQ-035 Wrap-around: run three fill/drain rounds of 8 distinct random words each; all 24 words SHALL read back in order.
REQ-036 Mid-operation reset: write 5 words, then apply RST=0 for 1 edge.
- Required: EMPTY=1 and FULL=0.
- A subsequent write of 0xA5 reads back as 0xA5.
